// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART receive/transmit blocks.
package spart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    localparam logic [1:0] ADDR_RXBUF  = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DIVLO  = 2'b10;
    localparam logic [1:0] ADDR_DIVHI  = 2'b11;

    localparam int RX_OVERSAMPLE = 16;
    localparam int RX_DATA_BITS  = 8;

endpackage

// File: rtl/spart_sync.sv
// Multi-flop synchronizer for an asynchronous, idle-high input line.
module spart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: oversampled 8N1 framing with RDA, framing-error and overrun flags.
module spart_rx
    import spart_pkg::*;
#(
    parameter int DATA_BITS   = RX_DATA_BITS,
    parameter int OVERSAMPLE  = RX_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 rxd,
    input  logic                 iocs,
    input  logic                 iorw,
    input  logic [1:0]           ioaddr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 framing_err,
    output logic                 overrun
);

    localparam int              TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]   TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]   TICK_LAST = '1;
    localparam logic [2:0]      BIT_LAST  = 3'(DATA_BITS - 1);

    rx_state_e             state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [2:0]            bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rda_q, rda_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;
    logic                  rxd_s;
    logic                  bus_rd;
    logic                  done;

    spart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rxd),
        .q_o (rxd_s)
    );

    assign bus_rd = iocs && iorw && (ioaddr == ADDR_RXBUF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            rda_q     <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            rda_q     <= rda_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        rda_d     = rda_q;
        ferr_d    = ferr_q;
        ovr_d     = ovr_q;
        done      = 1'b0;

        if (enable) begin
            unique case (state_q)
                IDLE: begin
                    if (!rxd_s) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        // A start bit that is high again at mid-bit was a glitch.
                        state_d = rxd_s ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                DATA: begin
                    tick_d = tick_q + TW'(1);
                    if (tick_q == TICK_LAST) begin
                        shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end
                end
                STOP: begin
                    tick_d = tick_q + TW'(1);
                    if (tick_q == TICK_LAST) begin
                        done    = 1'b1;
                        state_d = rxd_s ? IDLE : WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (rxd_s) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A read coinciding with completion consumes the old byte, so no overrun.
        if (done) begin
            rx_data_d = shift_q;
            rda_d     = 1'b1;
            ferr_d    = !rxd_s;
            ovr_d     = rda_q && !bus_rd;
        end else if (bus_rd) begin
            rda_d  = 1'b0;
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
    end

    assign rx_data     = rx_data_q;
    assign rda         = rda_q;
    assign framing_err = ferr_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx: enable tick every 4 clk, frames driven tick-aligned.
module tb_spart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       rxd;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] rx_data;
    logic       rda;
    logic       framing_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    spart_rx dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .rxd         (rxd),
        .iocs        (iocs),
        .iorw        (iorw),
        .ioaddr      (ioaddr),
        .rx_data     (rx_data),
        .rda         (rda),
        .framing_err (framing_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        enable = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 enable = 1'b1;
            @(posedge clk);
            #1 enable = 1'b0;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_rx(input string tag, input logic [7:0] d, input logic r,
                          input logic f, input logic o);
        chk({tag, ".data"}, rx_data, d);
        chk({tag, ".rda"}, {7'b0, rda}, {7'b0, r});
        chk({tag, ".ferr"}, {7'b0, framing_err}, {7'b0, f});
        chk({tag, ".ovr"}, {7'b0, overrun}, {7'b0, o});
    endtask

    // Returns 2 ns after the n-th enabled clock edge from now.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!enable) @(posedge clk);
        end
        #2;
    endtask

    task automatic bus_read(input logic [1:0] a);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        @(posedge clk);
        #2 iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
    endtask

    // Start edge at tick k; the stop sample (completion) lands on tick k+153.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input bit rd_at_done, input bit chk_lat);
        rxd = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_ticks(16);
        end
        rxd = stop;
        wait_ticks(8);
        if (rd_at_done) begin
            repeat (3) @(posedge clk);
            #2 iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
            @(posedge clk);
            #2 iocs = 1'b0; iorw = 1'b0;
            wait_ticks(7);
        end else if (chk_lat) begin
            chk("lat152", {7'b0, rda}, 8'h00);
            wait_ticks(1);
            chk("lat153", {7'b0, rda}, 8'h01);
            wait_ticks(7);
        end else begin
            wait_ticks(8);
        end
        if (stop) rxd = 1'b1;
    endtask

    initial begin
        rst = 1'b1; rxd = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
        repeat (3) @(posedge clk);
        #2;
        chk_rx("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        wait_ticks(4);

        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        chk_rx("a5", 8'hA5, 1'b1, 1'b0, 1'b0);

        rxd = 1'b0;
        wait_ticks(5);
        rxd = 1'b1;
        wait_ticks(20);
        chk_rx("glitch", 8'hA5, 1'b1, 1'b0, 1'b0);
        bus_read(2'b01);
        chk("status_rd.rda", {7'b0, rda}, 8'h01);
        bus_read(2'b00);
        chk_rx("rd_a5", 8'hA5, 1'b0, 1'b0, 1'b0);

        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        chk_rx("3c", 8'h3C, 1'b1, 1'b0, 1'b0);
        bus_read(2'b00);

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        wait_ticks(40);
        chk_rx("brk", 8'h3C, 1'b1, 1'b1, 1'b0);
        rxd = 1'b1;
        wait_ticks(4);
        bus_read(2'b00);
        chk_rx("brk_rd", 8'h3C, 1'b0, 1'b0, 1'b0);
        wait_ticks(170);
        chk("brk_single.rda", {7'b0, rda}, 8'h00);
        send_frame(8'h96, 1'b1, 1'b0, 1'b0);
        chk_rx("after_brk", 8'h96, 1'b1, 1'b0, 1'b0);
        bus_read(2'b00);

        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        chk_rx("ovr", 8'h22, 1'b1, 1'b0, 1'b1);
        bus_read(2'b00);
        chk_rx("ovr_rd", 8'h22, 1'b0, 1'b0, 1'b0);

        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1, 1'b0);
        chk_rx("simul", 8'h22, 1'b1, 1'b0, 1'b0);

        // Abort a frame while bit 4 is on the line.
        rxd = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 5; i++) begin
            rxd = i[0];
            wait_ticks(16);
        end
        #1 rst = 1'b1;
        #1;
        chk_rx("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        rxd = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        wait_ticks(20);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        chk_rx("5a", 8'h5A, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
